serial_parity_checker: RTL and testbench
========================================

# serial_parity_checker

Receives a serial bit stream (typically the output of the team's XOR/parity generation stage) one bit per handshake. Assembles each frame of `FRAME_BITS` data bits followed by one parity bit, and checks the received parity against the XOR of the data bits. Presents the recovered word and a parity-error flag to the downstream consumer over a valid/ready handshake. Keeps a saturating count of parity errors.

## Interface
Parameters:
- `FRAME_BITS`, 8: data bits per frame, legal range 2..32.
- `ODD_PARITY`, 0: 0 selects even parity (parity bit = XOR of data); 1 selects odd parity (parity bit = inverted XOR).
- `ERR_CNT_W`, 8: width of the error counter.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `in_valid`, input, 1: `in_bit` is valid this cycle.
- `in_bit`, input, 1: serial data; LSB of the word first, parity bit last.
- `in_ready`, output, 1: the block accepts `in_bit` this cycle.
- `out_valid`, output, 1: `out_data` and `out_parity_err` are valid.
- `out_ready`, input, 1: the consumer accepts the output this cycle.
- `out_data`, output, `FRAME_BITS`: recovered word.
- `out_parity_err`, output, 1: received parity does not match computed parity.
- `err_count`, output, `ERR_CNT_W`: number of frames with a parity error; saturates at all-ones.
- `busy`, output, 1: a frame is partially received (state PARITY, or state COLLECT with bit count > 0).

## Operation
- FSM states:
  - COLLECT: receives data bits.
  - PARITY: receives the parity bit.
  - HOLD: presents the result.
- Input transfer: an input bit is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in COLLECT and PARITY, 0 in HOLD.
- COLLECT, on each accepted bit:
  - Write the bit into `shift[bit_cnt]`, so the word is assembled LSB-first.
  - Update the running parity: `par <= par ^ in_bit`.
  - Increment `bit_cnt`.
  - When the accepted bit is number `FRAME_BITS-1`, go to PARITY and clear `bit_cnt`.
- PARITY, on the accepted bit:
  - Compute `err = in_bit ^ par ^ ODD_PARITY`.
  - Latch `out_data = shift` and `out_parity_err = err`.
  - If `err` is 1 and the counter is not saturated, increment `err_count`.
  - Go to HOLD.
- HOLD:
  - `out_valid` = 1.
  - `out_data` and `out_parity_err` are stable until the output handshake.
  - When `out_ready` = 1: go to COLLECT and clear `par` and `shift`.
- Cycles with `in_valid` = 0 (bubbles) in COLLECT or PARITY change no state.
- Reset (`rst_n` = 0 at a clock edge) takes priority over everything and can land in any state, including mid-frame. A partial frame is discarded.
- Reset values:
  - state = COLLECT, `bit_cnt` = 0, `par` = 0, `shift` = 0.
  - `out_data` = 0, `out_parity_err` = 0, `out_valid` = 0, `err_count` = 0.
  - `in_ready` = 1, `busy` = 0.
- `err_count` at all-ones stays at all-ones on further errors. It is cleared only by reset.

## Timing
- Minimum frame time: `FRAME_BITS+1` accepted cycles, then at least 1 HOLD cycle.
- Latency: `out_valid` rises on the clock edge that accepts the parity bit, i.e. visible in the cycle after the parity bit was presented.
- `err_count` updates on the same edge as `out_valid` rises.
- The HOLD exit edge (`out_ready` = 1) makes `in_ready` = 1 in the next cycle. There is no input/output overlap, so the throughput ceiling is 1 frame per `FRAME_BITS+2` cycles.
- `in_valid` asserted while `in_ready` = 0: the bit is not consumed, and the upstream holds it.
- `out_ready` asserted while `out_valid` = 0: ignored.
- All outputs are registered except `in_ready` and `busy`, which are decoded from state and `bit_cnt`.

## Structure
- Shared package `parity_pkg`:
  - state enum `parity_state_t` {COLLECT, PARITY, HOLD}.
  - constant `PARITY_EVEN` = 0 and `PARITY_ODD` = 1.
- One sub-module is natural: `parity_accum`.
  - Holds the running XOR register.
  - Inputs: `en`, `clr`, `bit`.
  - Output: `par`.
  - Same clock and reset as the parent.
- `bit_cnt` width: `$clog2(FRAME_BITS)`.

## Test plan
All cases use `FRAME_BITS`=8, `ODD_PARITY`=0 unless noted.
1. Good frame: send 0xA5 as bits 1,0,1,0,0,1,0,1, then parity 0, with `out_ready`=1 → `out_data`=0xA5, `out_parity_err`=0, `err_count`=0.
2. Bad parity: send 0x07, then parity 0 → `out_parity_err`=1, `err_count`=1. Then send 0x07 with parity 1 → `out_parity_err`=0, `err_count` stays at 1.
3. Backpressure and bubbles: insert random `in_valid` gaps and hold `out_ready`=0 for 5 cycles → `out_data` is stable for all 5 cycles, `in_ready`=0 throughout HOLD, and 0x3C is recovered intact.
4. Reset mid-frame: assert `rst_n`=0 after 4 bits → `busy`=0, `out_valid`=0. A fresh 0xFF frame with parity 0 then gives `out_data`=0xFF, `err`=0.
5. Saturation: use `ERR_CNT_W`=2 and send 5 bad frames → `err_count` reads 1, 2, 3, 3, 3.
6. Odd parity: use `ODD_PARITY`=1 and send 0x01 with parity 0 → `err`=0; send 0x01 with parity 1 → `err`=1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity checker.
package parity_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PARITY  = 2'd1,
    HOLD    = 2'd2
  } parity_state_t;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/parity_accum.sv
// Running XOR of the accepted data bits of the frame in flight.
module parity_accum (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic bit_i,
  output logic par_o
);

  logic par_q;

  // Clear wins over accumulate so a frame boundary always starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (clr_i) begin
      par_q <= 1'b0;
    end else if (en_i) begin
      par_q <= par_q ^ bit_i;
    end else begin
      par_q <= par_q;
    end
  end

  assign par_o = par_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames plus a trailing parity bit, flags parity
// errors and hands each word downstream over a valid/ready handshake.
module serial_parity_checker #(
  parameter int FRAME_BITS = 8,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_bit,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAME_BITS-1:0] out_data,
  output logic                  out_parity_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  busy
);

  import parity_pkg::*;

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic ODD_BIT = (ODD_PARITY != PARITY_EVEN);

  parity_state_t         state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] out_data_q;
  logic                  out_err_q;
  logic                  out_valid_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d;

  logic acc_en_s;
  logic acc_clr_s;
  logic par_s;
  logic err_s;

  assign acc_en_s  = (state_q == COLLECT) && in_valid;
  assign acc_clr_s = (state_q == HOLD) && out_ready;

  parity_accum u_accum (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (acc_en_s),
    .clr_i (acc_clr_s),
    .bit_i (in_bit),
    .par_o (par_s)
  );

  assign err_s = in_bit ^ par_s ^ ODD_BIT;

  // Saturating error counter next value.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_s && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Frame FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid) begin
            shift_q[bit_cnt_q] <= in_bit;
            if (bit_cnt_q == LAST_IDX) begin
              bit_cnt_q <= '0;
              state_q   <= PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (in_valid) begin
            out_data_q  <= shift_q;
            out_err_q   <= err_s;
            out_valid_q <= 1'b1;
            err_cnt_q   <= err_cnt_d;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            shift_q     <= '0;
            state_q     <= COLLECT;
          end
        end
        default: begin
          state_q     <= COLLECT;
          bit_cnt_q   <= '0;
          shift_q     <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = (state_q == COLLECT) || (state_q == PARITY);
  assign busy           = (state_q == PARITY) ||
                          ((state_q == COLLECT) && (bit_cnt_q != '0));
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_parity_err = out_err_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench: u0 default, u1 with a 2-bit error counter, u2 odd parity.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [3];
  logic       in_bit    [3];
  logic       out_ready [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic [7:0] od        [3];
  logic       perr      [3];
  logic       busy      [3];
  logic [7:0] ec0;
  logic [1:0] ec1;
  logic [7:0] ec2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_parity_checker u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_bit(in_bit[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(od[0]), .out_parity_err(perr[0]), .err_count(ec0), .busy(busy[0]));

  serial_parity_checker #(.ERR_CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_bit(in_bit[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(od[1]), .out_parity_err(perr[1]), .err_count(ec1), .busy(busy[1]));

  serial_parity_checker #(.ODD_PARITY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_bit(in_bit[2]),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(od[2]), .out_parity_err(perr[2]), .err_count(ec2), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit until the DUT accepts it (bounded).
  task automatic send_bit(input int idx, input logic b);
    logic rdy;
    int   n;
    in_valid[idx] = 1'b1;
    in_bit[idx]   = b;
    n = 0;
    forever begin
      rdy = in_ready[idx];
      tick();
      if (rdy) break;
      n++;
      if (n > 20) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid[idx] = 1'b0;
  endtask

  // gap > 0 inserts (i % gap) bubble cycles after each data bit.
  task automatic send_frame(input int idx, input logic [7:0] d, input logic p, input int gap);
    for (int i = 0; i < 8; i++) begin
      send_bit(idx, d[i]);
      if (gap > 0) begin
        for (int g = 0; g < (i % gap); g++) tick();
      end
    end
    send_bit(idx, p);
    chk("out_valid_rise", {31'd0, out_valid[idx]}, 32'd1);
    chk("in_ready_hold", {31'd0, in_ready[idx]}, 32'd0);
  endtask

  task automatic drain(input int idx);
    out_ready[idx] = 1'b1;
    tick();
    out_ready[idx] = 1'b0;
    chk("out_valid_fall", {31'd0, out_valid[idx]}, 32'd0);
    chk("in_ready_back", {31'd0, in_ready[idx]}, 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_bit[k] = 1'b0; out_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    chk("rst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_out_data", {24'd0, od[0]}, 32'd0);
    chk("rst_err_count", {24'd0, ec0}, 32'd0);

    // Good frame 0xA5, even parity 0.
    send_frame(0, 8'hA5, 1'b0, 0);
    chk("t1_data", {24'd0, od[0]}, 32'h0A5);
    chk("t1_err", {31'd0, perr[0]}, 32'd0);
    chk("t1_cnt", {24'd0, ec0}, 32'd0);
    drain(0);

    // 0x07 has odd weight: parity 0 is wrong, 1 is right.
    send_frame(0, 8'h07, 1'b0, 0);
    chk("t2a_data", {24'd0, od[0]}, 32'h007);
    chk("t2a_err", {31'd0, perr[0]}, 32'd1);
    chk("t2a_cnt", {24'd0, ec0}, 32'd1);
    drain(0);
    send_frame(0, 8'h07, 1'b1, 0);
    chk("t2b_err", {31'd0, perr[0]}, 32'd0);
    chk("t2b_cnt", {24'd0, ec0}, 32'd1);
    drain(0);

    // Bubbles, then held output for 5 cycles.
    send_frame(0, 8'h3C, 1'b0, 3);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_stable_data", {24'd0, od[0]}, 32'h03C);
      chk("t3_in_ready", {31'd0, in_ready[0]}, 32'd0);
      chk("t3_valid", {31'd0, out_valid[0]}, 32'd1);
    end
    chk("t3_err", {31'd0, perr[0]}, 32'd0);
    drain(0);

    // Reset after 4 bits discards the partial frame.
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    chk("t4_busy_mid", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_busy", {31'd0, busy[0]}, 32'd0);
    chk("t4_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("t4_cnt", {24'd0, ec0}, 32'd0);
    send_frame(0, 8'hFF, 1'b0, 0);
    chk("t4_data", {24'd0, od[0]}, 32'h0FF);
    chk("t4_err", {31'd0, perr[0]}, 32'd0);
    drain(0);

    // Saturation on a 2-bit counter.
    for (int f = 0; f < 5; f++) begin
      send_frame(1, 8'h07, 1'b0, 0);
      chk("t5_err", {31'd0, perr[1]}, 32'd1);
      chk("t5_cnt", {30'd0, ec1}, (f < 3) ? 32'(f + 1) : 32'd3);
      drain(1);
    end

    // Odd parity: 0x01 already has odd weight, so parity 0 is correct.
    send_frame(2, 8'h01, 1'b0, 0);
    chk("t6a_err", {31'd0, perr[2]}, 32'd0);
    chk("t6a_data", {24'd0, od[2]}, 32'h001);
    drain(2);
    send_frame(2, 8'h01, 1'b1, 0);
    chk("t6b_err", {31'd0, perr[2]}, 32'd1);
    chk("t6b_cnt", {24'd0, ec2}, 32'd1);
    drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
